// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit CPU: owns PC and IR, fetches
// 1- or 2-byte instructions over a req/ready bus and strobes the datapath.
module cpu_sequencer #(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DATA_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              zero_flag,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        alu_op,
   output logic              reg_write,
   output logic              load_a,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic              busy,
   output logic              halted,
   output logic              illegal
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_FETCH_OP,
      S_MEM,
      S_EXEC,
      S_HALT
   } state_e;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ALU  = 4'h1,
      OP_LDA  = 4'h2,
      OP_STA  = 4'h3,
      OP_JMP  = 4'h4,
      OP_JZ   = 4'h5,
      OP_HALT = 4'hF
   } opclass_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   opr_q, opr_d;
   logic                illegal_q, illegal_d;

   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                reg_write_q, reg_write_d;
   logic [3:0]          alu_op_q, alu_op_d;

   logic [3:0]          op_cls;
   logic [ADDR_W-1:0]   pc_inc;

   assign op_cls = ir_q[7:4];
   assign pc_inc = pc_q + ADDR_W'(1);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      opr_d     = opr_q;
      illegal_d = illegal_q;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = pc_inc;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (op_cls)
               OP_NOP:                        state_d = S_FETCH;
               OP_ALU:                        state_d = S_EXEC;
               OP_LDA, OP_STA, OP_JMP, OP_JZ: state_d = S_FETCH_OP;
               OP_HALT:                       state_d = S_HALT;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
            endcase
         end
         S_FETCH_OP: begin
            if (mem_ready) begin
               opr_d   = mem_rdata;
               pc_d    = pc_inc;
               state_d = S_FETCH;
               if (op_cls == OP_LDA || op_cls == OP_STA) state_d = S_MEM;
               if (op_cls == OP_JMP || (op_cls == OP_JZ && zero_flag))
                  pc_d = ADDR_W'(mem_rdata);
            end
         end
         S_MEM: begin
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC:  state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      // Bus and strobe outputs are registered, so they are derived from the next state.
      mem_req_d   = state_d inside {S_FETCH, S_FETCH_OP, S_MEM};
      mem_we_d    = (state_d == S_MEM) && (ir_d[7:4] == OP_STA);
      mem_addr_d  = (state_d == S_MEM) ? ADDR_W'(opr_d) : pc_d;
      reg_write_d = (state_d == S_EXEC);
      alu_op_d    = reg_write_d ? ir_d[3:0] : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         opr_q       <= '0;
         illegal_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= RESET_PC;
         reg_write_q <= 1'b0;
         alu_op_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         opr_q       <= opr_d;
         illegal_q   <= illegal_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         reg_write_q <= reg_write_d;
         alu_op_q    <= alu_op_d;
      end
   end

   // LDA data is captured by the datapath on the completing cycle itself.
   assign load_a    = (state_q == S_MEM) && (op_cls == OP_LDA) && mem_ready;

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign reg_write = reg_write_q;
   assign alu_op    = alu_op_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign illegal   = illegal_q;
   assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-level program model predicts bus
// transfers, strobes, final PC/flags and cycle count; memory adds wait states.
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       mem_ready = 1'b0;
   logic [7:0] mem_rdata = '0;
   logic       zero_flag = 1'b0;
   logic       mem_req, mem_we, reg_write, load_a, busy, halted, illegal;
   logic [7:0] mem_addr, pc, ir;
   logic [3:0] alu_op;

   cpu_sequencer #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .zero_flag(zero_flag), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .alu_op(alu_op),
      .reg_write(reg_write), .load_a(load_a), .pc(pc), .ir(ir),
      .busy(busy), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  mem [256];
   int          obs[$];
   int          exp_q[$];
   logic [7:0]  exp_pc;
   logic        exp_ill;
   int          exp_cyc;
   int          wait_mode = 0, wait_fixed = 0, cur_wait = 0, cnt = 0, total_waits = 0;
   bit          completed_last = 0, pend = 0, mon_en = 0;
   logic [7:0]  pend_addr;
   logic        pend_we;

   function automatic int pick_wait();
      return (wait_mode != 0) ? int'($urandom_range(0, 2)) : wait_fixed;
   endfunction

   // Memory responder and bus/strobe monitor; events encoded as kind*256+value.
   always @(negedge clk) begin
      if (completed_last) begin
         cnt = 0;
         cur_wait = pick_wait();
         completed_last = 0;
      end
      if (mon_en && pend) begin
         checks++;
         assert (mem_req === 1'b1 && mem_addr === pend_addr && mem_we === pend_we)
         else begin
            errors++;
            $error("FAIL hold: req=%b addr=%h we=%b, expected req=1 addr=%h we=%b",
                   mem_req, mem_addr, mem_we, pend_addr, pend_we);
         end
      end
      if (mem_req === 1'b1) begin
         if (cnt >= cur_wait) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr];
            completed_last = 1;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = 8'($urandom);
            cnt++;
            total_waits++;
         end
      end else begin
         mem_ready = (wait_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_rdata = 8'($urandom);
         cnt = 0;
      end
      pend      = (mem_req === 1'b1) && !mem_ready;
      pend_addr = mem_addr;
      pend_we   = mem_we;
      #1;
      if (mon_en) begin
         if (mem_req === 1'b1 && mem_ready) obs.push_back((mem_we ? 2 : 1) * 256 + int'(mem_addr));
         if (load_a === 1'b1) obs.push_back(4 * 256 + int'(mem_addr));
         if (reg_write === 1'b1) obs.push_back(3 * 256 + int'(alu_op));
         else begin
            checks++;
            assert (alu_op === 4'd0)
            else begin
               errors++;
               $error("FAIL alu_op_idle: got %h, expected 0", alu_op);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e)
      else begin
         errors++;
         $error("FAIL %s: got %0h, expected %0h", tag, o, e);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mon_en = 0;
      pend = 0;
      completed_last = 0;
      cnt = 0;
      cur_wait = pick_wait();
      start = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Instruction-level interpreter over the memory image.
   task automatic model_run(input bit z);
      logic [7:0] p, op, a;
      int n;
      exp_q.delete();
      exp_ill = 1'b0;
      exp_cyc = 0;
      p = 8'h00;
      for (n = 0; n < 300; n++) begin
         exp_q.push_back(256 + int'(p));
         op = mem[p];
         p = p + 8'd1;
         if (op[7:4] == 4'h0) exp_cyc += 2;
         else if (op[7:4] == 4'h1) begin
            exp_q.push_back(3 * 256 + int'(op[3:0]));
            exp_cyc += 3;
         end else if (op[7:4] == 4'h2 || op[7:4] == 4'h3) begin
            exp_q.push_back(256 + int'(p));
            a = mem[p];
            p = p + 8'd1;
            exp_q.push_back(((op[7:4] == 4'h2) ? 256 : 512) + int'(a));
            if (op[7:4] == 4'h2) exp_q.push_back(4 * 256 + int'(a));
            exp_cyc += 4;
         end else if (op[7:4] == 4'h4) begin
            exp_q.push_back(256 + int'(p));
            p = mem[p];
            exp_cyc += 3;
         end else if (op[7:4] == 4'h5) begin
            exp_q.push_back(256 + int'(p));
            p = z ? mem[p] : p + 8'd1;
            exp_cyc += 3;
         end else begin
            exp_ill = (op[7:4] != 4'hF);
            exp_cyc += 2;
            break;
         end
      end
      exp_pc = p;
   endtask

   task automatic run_prog(input string tag, input bit z, input int mode, input int wfix);
      int cyc, waits;
      bit seen;
      wait_mode = mode;
      wait_fixed = wfix;
      zero_flag = z;
      do_reset();
      model_run(z);
      obs.delete();
      total_waits = 0;
      mon_en = 1;
      start = 1'b1;
      cyc = 0;
      seen = 0;
      while (cyc < 3000 && !seen) begin
         @(negedge clk);
         #2;
         cyc++;
         start = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (halted === 1'b1) seen = 1;
      end
      waits = total_waits;
      chk({tag, "_halt_reached"}, 32'(seen), 32'd1);
      chk({tag, "_cycles"}, cyc, exp_cyc + waits + 1);
      start = 1'b1;
      repeat (4) @(negedge clk);
      #2;
      start = 1'b0;
      chk({tag, "_halted"}, halted, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_req_after_halt"}, mem_req, 1'b0);
      chk({tag, "_pc"}, pc, exp_pc);
      chk({tag, "_illegal"}, illegal, exp_ill);
      chk({tag, "_event_count"}, obs.size(), exp_q.size());
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
         chk({tag, "_event"}, obs[i], exp_q[i]);
      mon_en = 0;
   endtask

   task automatic fill_halt();
      foreach (mem[i]) mem[i] = 8'hF0;
   endtask

   task automatic gen_prog();
      logic [7:0] ops[16];
      logic [7:0] args[16];
      int kind[16];
      int off[17];
      int n, r, j;
      foreach (mem[i]) mem[i] = 8'($urandom);
      n = $urandom_range(3, 12);
      for (int k = 0; k < n; k++) begin
         r = $urandom_range(0, 19);
         kind[k] = 1;
         if (r == 0)       ops[k] = {4'($urandom_range(6, 14)), 4'($urandom)};
         else if (r < 4)   ops[k] = {4'h0, 4'($urandom)};
         else if (r < 8)   ops[k] = {4'h1, 4'($urandom)};
         else if (r < 11) begin ops[k] = 8'h20; kind[k] = 2; end
         else if (r < 14) begin ops[k] = 8'h30; kind[k] = 2; end
         else if (r < 16) begin ops[k] = 8'h40; kind[k] = 3; end
         else begin ops[k] = 8'h50; kind[k] = 3; end
      end
      ops[n] = {4'hF, 4'($urandom)};
      kind[n] = 1;
      off[0] = 0;
      for (int k = 0; k <= n; k++) off[k + 1] = off[k] + ((kind[k] == 1) ? 1 : 2);
      for (int k = 0; k < n; k++) begin
         if (kind[k] == 2) args[k] = 8'($urandom);
         if (kind[k] == 3) begin
            j = $urandom_range(k + 1, n);
            args[k] = 8'(off[j]);
         end
      end
      for (int k = 0; k <= n; k++) begin
         mem[8'(off[k])] = ops[k];
         if (kind[k] != 1) mem[8'(off[k] + 1)] = args[k];
      end
   endtask

   initial begin
      fill_halt();
      do_reset();
      chk("rst_pc", pc, 8'h00);
      chk("rst_ir", ir, 8'h00);
      chk("rst_illegal", illegal, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_strobes", {reg_write, load_a, alu_op}, 6'd0);

      fill_halt(); mem[0] = 8'h00; mem[1] = 8'hF0;
      run_prog("nop_halt", 1'b0, 0, 0);
      chk("nop_halt_pc_const", pc, 8'h02);

      fill_halt(); mem[0] = 8'h13;
      run_prog("alu", 1'b0, 0, 0);

      fill_halt(); mem[0] = 8'h20; mem[1] = 8'h40; mem[8'h40] = 8'h5A; mem[2] = 8'hF0;
      run_prog("lda_wait3", 1'b0, 0, 3);
      chk("lda_pc_const", pc, 8'h03);

      fill_halt(); mem[0] = 8'h30; mem[1] = 8'h80;
      run_prog("sta", 1'b0, 0, 0);

      fill_halt(); mem[0] = 8'h50; mem[1] = 8'h10;
      run_prog("jz_taken", 1'b1, 0, 0);
      chk("jz_taken_pc_const", pc, 8'h11);
      run_prog("jz_not_taken", 1'b0, 0, 0);
      chk("jz_not_taken_pc_const", pc, 8'h03);

      fill_halt(); mem[0] = 8'h40; mem[1] = 8'hFE; mem[8'hFE] = 8'h40; mem[8'hFF] = 8'h05;
      run_prog("jmp_wrap", 1'b0, 0, 0);
      chk("jmp_wrap_pc_const", pc, 8'h06);

      fill_halt(); mem[0] = 8'h40; mem[1] = 8'hFF; mem[8'hFF] = 8'h50;
      run_prog("jz_opr_at_00_nt", 1'b0, 0, 1);
      run_prog("jz_opr_at_00_t", 1'b1, 0, 0);

      fill_halt(); mem[0] = 8'h70;
      run_prog("illegal", 1'b0, 0, 0);
      chk("illegal_const", illegal, 1'b1);

      for (int t = 0; t < 30; t++) begin
         gen_prog();
         run_prog("rand", 1'($urandom_range(0, 1)), 1, 0);
      end

      fill_halt(); mem[0] = 8'h00;
      wait_mode = 0;
      wait_fixed = 1000;
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      chk("midfetch_req_before", mem_req, 1'b1);
      reset = 1'b1;
      #1;
      chk("midfetch_req_drop", mem_req, 1'b0);
      chk("midfetch_pc", pc, 8'h00);
      chk("midfetch_illegal", illegal, 1'b0);
      chk("midfetch_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      chk("after_reset_idle_busy", busy, 1'b0);
      chk("after_reset_idle_req", mem_req, 1'b0);
      chk("after_reset_idle_halted", halted, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
